// File: rtl/fetch_pc_redirect_unit.sv
// Fetch-stage PC sequencer: holds the fetch PC, drives the imem request and
// applies (or buffers, while stalled) branch / jump / jump-register redirects.
module fetch_pc_redirect_unit #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              stall,
    input  logic              imem_ready,
    output logic              imem_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              flush_if_id,
    output logic              pending_redirect,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] tgt_q;
    logic              redir_req;
    logic [ADDR_W-1:0] redir_tgt;
    logic              fire;
    logic              do_apply;
    logic [ADDR_W-1:0] apply_tgt;

    // The EX-stage branch is older than any ID-stage jump, so it wins.
    always_comb begin
        redir_req = branch_taken | jr | jump;
        redir_tgt = jump_target;
        if (branch_taken)
            redir_tgt = branch_target;
        else if (jr)
            redir_tgt = jr_target;
    end

    // In HOLD a new branch supersedes the buffered target; jump/jr are ignored.
    always_comb begin
        fire      = imem_valid & imem_ready & ~stall;
        do_apply  = 1'b0;
        apply_tgt = redir_tgt;
        if (state == RUN) begin
            do_apply = fire & redir_req;
        end else if (state == HOLD) begin
            do_apply  = fire;
            apply_tgt = branch_taken ? branch_target : tgt_q;
        end
    end

    assign pc_plus4 = pc + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= ADDR_W'(RESET_PC);
            tgt_q            <= '0;
            imem_valid       <= 1'b0;
            flush_if_id      <= 1'b0;
            pending_redirect <= 1'b0;
            misalign_err     <= 1'b0;
            redirect_count   <= '0;
        end else begin
            flush_if_id <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= RUN;
                    imem_valid <= 1'b1;
                end
                RUN: begin
                    if (redir_req && !fire) begin
                        tgt_q            <= redir_tgt;
                        state            <= HOLD;
                        pending_redirect <= 1'b1;
                    end else if (!redir_req && fire) begin
                        pc <= pc_plus4;
                    end
                end
                HOLD: begin
                    if (fire) begin
                        state            <= RUN;
                        pending_redirect <= 1'b0;
                    end else if (branch_taken) begin
                        tgt_q <= branch_target;
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_valid <= 1'b0;
                end
            endcase
            if (do_apply) begin
                pc          <= apply_tgt;
                flush_if_id <= 1'b1;
                if (redirect_count != '1)
                    redirect_count <= redirect_count + CNT_W'(1);
                if (apply_tgt[1:0] != 2'b00)
                    misalign_err <= 1'b1;
            end
        end
    end

endmodule
